// File: rtl/sweep_pkg.sv
// Shared encodings for the DAC code sweep generator: command opcodes and
// sweep FSM states.
package sweep_pkg;

    typedef enum logic [1:0] {
        OPC_ARM   = 2'b00,
        OPC_HOLD  = 2'b01,
        OPC_STEP  = 2'b10,
        OPC_ABORT = 2'b11
    } opc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage : sweep_pkg

// File: rtl/sweep_dwell_timer.sv
// Terminal-count counter used to stretch each sweep step over limit_i+1
// consecutive enabled cycles. tc_o is combinational and marks the enabled
// cycle on which the step may advance; the count then restarts from zero.
module sweep_dwell_timer #(
    parameter int DwellWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DwellWidth-1:0] limit_i,
    output logic                  tc_o
);

    logic [DwellWidth-1:0] cnt_d, cnt_q;

    // Terminal count reached on an enabled cycle.
    assign tc_o = en_i && (cnt_q == limit_i);

    // Next count: clear wins, otherwise count enabled cycles and wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sweep_dwell_timer

// File: rtl/sweep_counter.sv
// DAC code sweep generator for bolometer bias sweeps. Commands ARM / HOLD /
// STEP / ABORT drive a ramp from a latched start code to a latched stop code,
// either once (mode 0) or as a continuous triangle (mode 1). Endpoints are
// clamped exactly and the count never wraps.
// Optional build macro SWEEP_DWELL_EN adds a dwell_i input: each step then
// advances only after dwell_i+1 consecutive STEP cycles.
module sweep_counter
    import sweep_pkg::*;
#(
    parameter int Width = 12
`ifdef SWEEP_DWELL_EN
    ,
    parameter int DwellWidth = 8
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       opc_i,
    input  logic [Width-1:0] start_i,
    input  logic [Width-1:0] stop_i,
    input  logic [Width-1:0] step_i,
    input  logic             mode_i,
`ifdef SWEEP_DWELL_EN
    input  logic [DwellWidth-1:0] dwell_i,
`endif
    output logic [Width-1:0] count_o,
    output logic             dir_o,
    output logic             done_o,
    output logic             cycle_o
);

    opc_e             opc;
    state_e           state_d, state_q;
    logic [Width-1:0] count_d, count_q;
    logic [Width-1:0] start_d, start_q;
    logic [Width-1:0] stop_d, stop_q;
    logic [Width-1:0] step_d, step_q;
    logic             mode_d, mode_q;
    logic             dir_d, dir_q;
    logic             done_d, done_q;
    logic             cycle_d, cycle_q;
    logic             step_fire;
    // One extra bit so the sum shows overflow and the difference shows borrow.
    logic [Width:0]   nxt;
    logic [Width:0]   dif;

    assign opc = opc_e'(opc_i);
    assign nxt = {1'b0, count_q} + {1'b0, step_q};
    assign dif = {1'b0, count_q} - {1'b0, step_q};

`ifdef SWEEP_DWELL_EN
    logic [DwellWidth-1:0] dwell_d, dwell_q;
    logic                  dwell_tc;

    // Dwell length is latched with the rest of the sweep configuration.
    always_comb begin
        dwell_d = dwell_q;
        if (opc == OPC_ARM) dwell_d = dwell_i;
    end

    // Dwell length register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dwell_q <= '0;
        else         dwell_q <= dwell_d;
    end

    // Any non-STEP cycle breaks the run of consecutive STEPs.
    sweep_dwell_timer #(
        .DwellWidth(DwellWidth)
    ) u_dwell_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (opc != OPC_STEP),
        .en_i   (opc == OPC_STEP),
        .limit_i(dwell_q),
        .tc_o   (dwell_tc)
    );

    assign step_fire = (opc == OPC_STEP) && dwell_tc;
`else
    assign step_fire = (opc == OPC_STEP);
`endif

    // Command decode and sweep next-state logic.
    always_comb begin
        // NOTE: every target gets its hold value first so no path infers a latch.
        state_d = state_q;
        count_d = count_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        done_d  = done_q;
        cycle_d = 1'b0;

        unique case (opc)
            OPC_ABORT: begin
                count_d = '0;
                dir_d   = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            OPC_ARM: begin
                start_d = start_i;
                stop_d  = stop_i;
                step_d  = step_i;
                mode_d  = mode_i;
                count_d = start_i;
                dir_d   = 1'b0;
                // An empty or inverted range is reported as done immediately.
                if (start_i >= stop_i) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    done_d  = 1'b0;
                    state_d = ST_UP;
                end
            end
            OPC_STEP: begin
                if (step_fire) begin
                    unique case (state_q)
                        ST_UP: begin
                            if (nxt >= {1'b0, stop_q}) begin
                                count_d = stop_q;
                                if (mode_q) begin
                                    dir_d   = 1'b1;
                                    state_d = ST_DOWN;
                                end else begin
                                    done_d  = 1'b1;
                                    state_d = ST_DONE;
                                end
                            end else begin
                                count_d = nxt[Width-1:0];
                            end
                        end
                        ST_DOWN: begin
                            if (dif[Width] || (dif[Width-1:0] <= start_q)) begin
                                count_d = start_q;
                                dir_d   = 1'b0;
                                cycle_d = 1'b1;
                                state_d = ST_UP;
                            end else begin
                                count_d = dif[Width-1:0];
                            end
                        end
                        default: ;  // IDLE and DONE ignore STEP
                    endcase
                end
            end
            default: ;  // HOLD keeps everything
        endcase
    end

    // Sweep state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses <= so all flops sample pre-edge values together.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            cycle_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            cycle_q <= cycle_d;
        end
    end

    assign count_o = count_q;
    assign dir_o   = dir_q;
    assign done_o  = done_q;
    assign cycle_o = cycle_q;

endmodule : sweep_counter

// File: tb/tb_sweep_counter.sv
// Directed self-checking bench for sweep_counter. Expected values are
// hand-computed from the sweep behaviour; dwell checks run only when
// SWEEP_DWELL_EN is defined.
module tb_sweep_counter;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   opc;
    logic [W-1:0] start_v, stop_v, step_v;
    logic         mode;
    logic [W-1:0] count;
    logic         dir, done, cyc;
`ifdef SWEEP_DWELL_EN
    logic [7:0]   dwell;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sweep_counter #(.Width(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .opc_i  (opc),
        .start_i(start_v),
        .stop_i (stop_v),
        .step_i (step_v),
        .mode_i (mode),
`ifdef SWEEP_DWELL_EN
        .dwell_i(dwell),
`endif
        .count_o(count),
        .dir_o  (dir),
        .done_o (done),
        .cycle_o(cyc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one command for one clock, then sample 1 time unit after the edge.
    task automatic cmd(input logic [1:0] c);
        @(negedge clk);
        opc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int s, input int e, input int st, input logic m);
        start_v = W'(s);
        stop_v  = W'(e);
        step_v  = W'(st);
        mode    = m;
        cmd(2'b00);
    endtask

    task automatic expect_out(input string tag, input int c, input logic d,
                              input logic dn, input logic cy);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".dir"},   32'(dir),   32'(d));
        check({tag, ".done"},  32'(done),  32'(dn));
        check({tag, ".cycle"}, 32'(cyc),   32'(cy));
    endtask

    int tri_exp[9] = '{300, 600, 900, 1000, 700, 400, 100, 0, 300};
    bit tri_dir[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit tri_cyc[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        rst_n = 1'b0; opc = 2'b01; start_v = '0; stop_v = '0; step_v = '0; mode = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwell = '0;
`endif
        #23;
        expect_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // HOLD and STEP in IDLE leave everything at zero.
        for (int i = 0; i < 5; i++) begin
            cmd(2'b01);
            expect_out("hold_idle", 0, 0, 0, 0);
        end
        cmd(2'b10);
        expect_out("step_idle", 0, 0, 0, 0);

        // Single ramp 100 -> 400 by 100.
        arm(100, 400, 100, 1'b0);
        expect_out("ramp_arm", 100, 0, 0, 0);
        cmd(2'b10); expect_out("ramp_s1", 200, 0, 0, 0);
        cmd(2'b10); expect_out("ramp_s2", 300, 0, 0, 0);
        cmd(2'b10); expect_out("ramp_s3", 400, 0, 1, 0);
        cmd(2'b10); expect_out("ramp_s4", 400, 0, 1, 0);

        // Continuous triangle 0 <-> 1000 by 300.
        arm(0, 1000, 300, 1'b1);
        expect_out("tri_arm", 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cmd(2'b10);
            expect_out($sformatf("tri_s%0d", i + 1), tri_exp[i], tri_dir[i], 0, tri_cyc[i]);
        end

        // Top-of-range clamp without wrap.
        arm(4000, 4095, 200, 1'b0);
        expect_out("clamp_arm", 4000, 0, 0, 0);
        cmd(2'b10); expect_out("clamp_s1", 4095, 0, 1, 0);

        // Degenerate range reports done at once, in both modes.
        arm(500, 500, 10, 1'b0);
        expect_out("eq_arm", 500, 0, 1, 0);
        arm(600, 200, 10, 1'b1);
        expect_out("inv_arm", 600, 0, 1, 0);
        cmd(2'b10); expect_out("inv_step", 600, 0, 1, 0);

        // Zero step: count stays put, no transition.
        arm(10, 20, 0, 1'b0);
        cmd(2'b10); expect_out("zero_step", 10, 0, 0, 0);

        // Config inputs changed mid-sweep are ignored until re-ARM.
        arm(100, 400, 100, 1'b0);
        cmd(2'b10); expect_out("mid_s1", 200, 0, 0, 0);
        start_v = 12'd0; stop_v = 12'd300; step_v = 12'd50; mode = 1'b1;
        cmd(2'b10); expect_out("mid_s2", 300, 0, 0, 0);
        cmd(2'b10); expect_out("mid_s3", 400, 0, 1, 0);

        // ABORT returns to IDLE; further STEPs do nothing.
        cmd(2'b11); expect_out("abort", 0, 0, 0, 0);
        cmd(2'b10); expect_out("abort_step", 0, 0, 0, 0);

        // Asynchronous reset mid-clock, away from any edge.
        arm(0, 1000, 300, 1'b1);
        cmd(2'b10); cmd(2'b10); cmd(2'b10); cmd(2'b10);
        expect_out("pre_rst", 1000, 1, 0, 0);
        @(negedge clk);
        opc = 2'b01;
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        cmd(2'b10); expect_out("post_rst_step", 0, 0, 0, 0);

`ifdef SWEEP_DWELL_EN
        // Dwell of 2: each step needs 3 consecutive STEP cycles.
        dwell = 8'd2;
        arm(0, 1000, 10, 1'b0);
        cmd(2'b10); expect_out("dw_a1", 0, 0, 0, 0);
        cmd(2'b10); expect_out("dw_a2", 0, 0, 0, 0);
        cmd(2'b10); expect_out("dw_a3", 10, 0, 0, 0);
        cmd(2'b10); expect_out("dw_b1", 10, 0, 0, 0);
        cmd(2'b10); expect_out("dw_b2", 10, 0, 0, 0);
        cmd(2'b10); expect_out("dw_b3", 20, 0, 0, 0);
        cmd(2'b10); expect_out("dw_c1", 20, 0, 0, 0);
        cmd(2'b01); expect_out("dw_hold", 20, 0, 0, 0);
        cmd(2'b10); expect_out("dw_c2", 20, 0, 0, 0);
        cmd(2'b10); expect_out("dw_c3", 20, 0, 0, 0);
        cmd(2'b10); expect_out("dw_c4", 30, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sweep_counter
